// File: rtl/execute_stage.sv
// Execute stage: ALU, branch resolution and the registered execute/memory pipeline boundary.
// ALU codes follow the RISC-V {funct7[5], funct3} layout; any code not listed raises an exception.
module execute_stage (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_in_valid,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [3:0]  i_alu_control,
    input  logic        i_alu_control_exception,
    input  logic        i_branch_condition,
    input  logic        i_is_branch,
    input  logic        i_alu_src,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic [31:0] i_imm,
    input  logic [4:0]  i_rd,
    input  logic        i_reg_write,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    output logic        o_in_ready,
    output logic        o_out_valid,
    output logic [31:0] o_alu_result,
    output logic [31:0] o_store_data,
    output logic [4:0]  o_rd_out,
    output logic        o_reg_write_out,
    output logic        o_mem_read_out,
    output logic        o_mem_write_out,
    output logic        o_branch_taken,
    output logic [31:0] o_branch_target,
    output logic        o_exception_out
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    logic [31:0] w_op_b;
    logic [4:0]  w_shamt;
    logic [31:0] w_result;
    logic        w_illegal;
    logic        w_exception;
    logic        w_taken;

    logic        r_out_valid;
    logic [31:0] r_alu_result;
    logic [31:0] r_store_data;
    logic [4:0]  r_rd_out;
    logic        r_reg_write_out;
    logic        r_mem_read_out;
    logic        r_mem_write_out;
    logic        r_branch_taken;
    logic [31:0] r_branch_target;
    logic        r_exception_out;

    always_comb begin
        w_op_b    = i_alu_src ? i_imm : i_rs2_data;
        w_shamt   = w_op_b[4:0];
        w_result  = 32'd0;
        w_illegal = 1'b0;
        case (i_alu_control)
            ALU_ADD:  w_result = i_rs1_data + w_op_b;
            ALU_SUB:  w_result = i_rs1_data - w_op_b;
            ALU_SLL:  w_result = i_rs1_data << w_shamt;
            ALU_SLT:  w_result = {31'd0, $signed(i_rs1_data) < $signed(w_op_b)};
            ALU_SLTU: w_result = {31'd0, i_rs1_data < w_op_b};
            ALU_XOR:  w_result = i_rs1_data ^ w_op_b;
            ALU_SRL:  w_result = i_rs1_data >> w_shamt;
            ALU_SRA:  w_result = $unsigned($signed(i_rs1_data) >>> w_shamt);
            ALU_OR:   w_result = i_rs1_data | w_op_b;
            ALU_AND:  w_result = i_rs1_data & w_op_b;
            default:  w_illegal = 1'b1;
        endcase
        // An excepting instruction must never redirect fetch or touch architectural state.
        w_exception = i_alu_control_exception | w_illegal;
        w_taken     = i_is_branch & ((w_result != 32'd0) ^ i_branch_condition) & ~w_exception;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_valid     <= 1'b0;
            r_alu_result    <= 32'd0;
            r_store_data    <= 32'd0;
            r_rd_out        <= 5'd0;
            r_reg_write_out <= 1'b0;
            r_mem_read_out  <= 1'b0;
            r_mem_write_out <= 1'b0;
            r_branch_taken  <= 1'b0;
            r_branch_target <= 32'd0;
            r_exception_out <= 1'b0;
        end else if (i_flush || (!i_stall && !i_in_valid)) begin
            r_out_valid     <= 1'b0;
            r_reg_write_out <= 1'b0;
            r_mem_read_out  <= 1'b0;
            r_mem_write_out <= 1'b0;
            r_branch_taken  <= 1'b0;
            r_exception_out <= 1'b0;
        end else if (!i_stall) begin
            r_out_valid     <= 1'b1;
            r_alu_result    <= w_result;
            r_store_data    <= i_rs2_data;
            r_rd_out        <= i_rd;
            r_reg_write_out <= i_reg_write & ~w_exception;
            r_mem_read_out  <= i_mem_read & ~w_exception;
            r_mem_write_out <= i_mem_write & ~w_exception;
            r_branch_taken  <= w_taken;
            r_branch_target <= i_pc + i_imm;
            r_exception_out <= w_exception;
        end
    end

    assign o_in_ready      = ~i_stall;
    assign o_out_valid     = r_out_valid;
    assign o_alu_result    = r_alu_result;
    assign o_store_data    = r_store_data;
    assign o_rd_out        = r_rd_out;
    assign o_reg_write_out = r_reg_write_out;
    assign o_mem_read_out  = r_mem_read_out;
    assign o_mem_write_out = r_mem_write_out;
    assign o_branch_taken  = r_branch_taken;
    assign o_branch_target = r_branch_target;
    assign o_exception_out = r_exception_out;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: the driver pushes the predicted output state per edge,
// and a monitor pops and compares it one time unit after each rising edge.
module tb_execute_stage;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    typedef struct packed {
        logic        reset, valid, stall, flush;
        logic [3:0]  op;
        logic        exc, cond, isBranch, aluSrc;
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic        rw, mr, mw;
    } stim_t;

    typedef struct packed {
        logic        valid, taken, exc, rw, mr, mw;
        logic [31:0] result, store, target;
        logic [4:0]  rd;
        logic        checkData;
    } outState_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, inValid, stall, flush, aluExc, branchCond, isBranch, aluSrc;
    logic        regWrite, memRead, memWrite;
    logic [3:0]  aluControl;
    logic [31:0] pc, rs1Data, rs2Data, imm;
    logic [4:0]  rd;
    logic        inReady, outValid, regWriteOut, memReadOut, memWriteOut, branchTaken, exceptionOut;
    logic [31:0] aluResult, storeData, branchTarget;
    logic [4:0]  rdOut;

    execute_stage dut (
        .i_clk(clk), .i_reset(reset), .i_in_valid(inValid), .i_stall(stall), .i_flush(flush),
        .i_alu_control(aluControl), .i_alu_control_exception(aluExc),
        .i_branch_condition(branchCond), .i_is_branch(isBranch), .i_alu_src(aluSrc),
        .i_pc(pc), .i_rs1_data(rs1Data), .i_rs2_data(rs2Data), .i_imm(imm), .i_rd(rd),
        .i_reg_write(regWrite), .i_mem_read(memRead), .i_mem_write(memWrite),
        .o_in_ready(inReady), .o_out_valid(outValid), .o_alu_result(aluResult),
        .o_store_data(storeData), .o_rd_out(rdOut), .o_reg_write_out(regWriteOut),
        .o_mem_read_out(memReadOut), .o_mem_write_out(memWriteOut),
        .o_branch_taken(branchTaken), .o_branch_target(branchTarget),
        .o_exception_out(exceptionOut)
    );

    outState_t expQ[$];
    outState_t modelState;
    int vectorCount = 0;
    int missCount = 0;

    // Reference ALU from the instruction rules; returns {illegal, result}.
    function automatic logic [32:0] refAlu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        logic [4:0] sh = b[4:0];
        case (op)
            OP_ADD:  return {1'b0, a + b};
            OP_SUB:  return {1'b0, a + ~b + 32'd1};
            OP_SLL:  return {1'b0, a << sh};
            OP_SLT:  return {1'b0, 31'd0, (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)};
            OP_SLTU: return {1'b0, 31'd0, a < b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_SRL:  return {1'b0, a >> sh};
            OP_SRA:  return {1'b0, (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0)};
            OP_OR:   return {1'b0, a | b};
            OP_AND:  return {1'b0, a & b};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic outState_t nextState(stim_t s, outState_t p);
        outState_t n = p;
        logic [32:0] alu;
        logic exc;
        if (s.reset) begin
            n = '0;
            n.checkData = 1'b1;
        end else if (s.flush || (!s.stall && !s.valid)) begin
            {n.valid, n.taken, n.exc, n.rw, n.mr, n.mw, n.checkData} = '0;
        end else if (!s.stall) begin
            alu = refAlu(s.op, s.rs1, s.aluSrc ? s.imm : s.rs2);
            exc = s.exc || alu[32];
            n.valid  = 1'b1;
            n.exc    = exc;
            n.rw     = s.rw && !exc;
            n.mr     = s.mr && !exc;
            n.mw     = s.mw && !exc;
            n.taken  = s.isBranch && ((alu[31:0] != 32'd0) != s.cond) && !exc;
            n.result = alu[31:0];
            n.store  = s.rs2;
            n.target = s.pc + s.imm;
            n.rd     = s.rd;
            n.checkData = 1'b1;
        end
        return n;
    endfunction

    function automatic stim_t idleStim();
        stim_t s = '0;
        return s;
    endfunction

    task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] req);
        vectorCount++;
        if (act !== req) begin
            missCount++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, req);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        reset = s.reset; inValid = s.valid; stall = s.stall; flush = s.flush;
        aluControl = s.op; aluExc = s.exc; branchCond = s.cond; isBranch = s.isBranch;
        aluSrc = s.aluSrc; pc = s.pc; rs1Data = s.rs1; rs2Data = s.rs2; imm = s.imm;
        rd = s.rd; regWrite = s.rw; memRead = s.mr; memWrite = s.mw;
        modelState = nextState(s, modelState);
        expQ.push_back(modelState);
        #1;
        compareField("in_ready", {31'd0, inReady}, {31'd0, !s.stall});
    endtask

    task automatic checkOutput(input outState_t e);
        compareField("out_valid",     {31'd0, outValid},     {31'd0, e.valid});
        compareField("branch_taken",  {31'd0, branchTaken},  {31'd0, e.taken});
        compareField("exception_out", {31'd0, exceptionOut}, {31'd0, e.exc});
        compareField("reg_write_out", {31'd0, regWriteOut},  {31'd0, e.rw});
        compareField("mem_read_out",  {31'd0, memReadOut},   {31'd0, e.mr});
        compareField("mem_write_out", {31'd0, memWriteOut},  {31'd0, e.mw});
        if (e.checkData) begin
            compareField("alu_result",    aluResult,            e.result);
            compareField("store_data",    storeData,            e.store);
            compareField("branch_target", branchTarget,         e.target);
            compareField("rd_out",        {27'd0, rdOut},       {27'd0, e.rd});
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        stim_t s, b;
        modelState = '0;
        s = idleStim(); s.reset = 1'b1;
        applyStimulus(s);
        s.stall = 1'b1;
        applyStimulus(s);

        // Arithmetic and compare boundary cases.
        s = idleStim(); s.valid = 1'b1; s.op = OP_ADD; s.rs1 = 32'h7FFF_FFFF; s.rs2 = 32'd1;
        s.rw = 1'b1; s.rd = 5'd3;
        applyStimulus(s);
        s.op = OP_SLT; s.rs1 = 32'hFFFF_FFFF;
        applyStimulus(s);
        s.op = OP_SLTU;
        applyStimulus(s);
        s.op = OP_SRA; s.rs1 = 32'h8000_0000; s.imm = 32'd4; s.aluSrc = 1'b1; s.rs2 = 32'hDEAD_BEEF;
        applyStimulus(s);

        s = idleStim(); s.valid = 1'b1; s.op = OP_SUB; s.rs1 = 32'd5; s.rs2 = 32'd5;
        s.cond = 1'b1; s.isBranch = 1'b1; s.pc = 32'h100; s.imm = 32'h20;
        applyStimulus(s);
        s.cond = 1'b0;
        applyStimulus(s);

        // Hold A across a three-cycle stall while B waits at the input.
        s = idleStim(); s.valid = 1'b1; s.op = OP_ADD; s.rs1 = 32'd10; s.rs2 = 32'd20;
        s.rd = 5'd1; s.rw = 1'b1;
        applyStimulus(s);
        b = idleStim(); b.valid = 1'b1; b.op = OP_XOR; b.rs1 = 32'hF0F0_0000; b.rs2 = 32'h0FF0_1234;
        b.rd = 5'd2; b.mw = 1'b1; b.stall = 1'b1;
        repeat (3) applyStimulus(b);
        b.stall = 1'b0;
        applyStimulus(b);
        applyStimulus(idleStim());

        s.stall = 1'b0;
        applyStimulus(s);
        s.stall = 1'b1; s.flush = 1'b1;
        applyStimulus(s);
        s.flush = 1'b0;
        applyStimulus(s);

        s = idleStim(); s.valid = 1'b1; s.op = OP_ADD; s.exc = 1'b1; s.rw = 1'b1; s.mw = 1'b1;
        s.isBranch = 1'b1; s.cond = 1'b1; s.rs1 = 32'd7;
        applyStimulus(s);
        s = idleStim(); s.reset = 1'b1;
        applyStimulus(s);

        s = idleStim(); s.valid = 1'b1; s.op = 4'b1111; s.rs1 = 32'd9; s.rw = 1'b1;
        s.mr = 1'b1; s.isBranch = 1'b1; s.cond = 1'b1;
        applyStimulus(s);

        // Reset while a held instruction sits in the output register.
        s = idleStim(); s.valid = 1'b1; s.op = OP_OR; s.rs1 = 32'h55; s.rs2 = 32'hAA00; s.rw = 1'b1;
        applyStimulus(s);
        s.stall = 1'b1;
        applyStimulus(s);
        s.reset = 1'b1;
        applyStimulus(s);
        s = idleStim(); s.valid = 1'b1; s.op = OP_SLL; s.rs1 = 32'd3; s.imm = 32'd33;
        s.aluSrc = 1'b1; s.rd = 5'd31; s.mr = 1'b1;
        applyStimulus(s);

        for (int i = 0; i < 400; i++) begin
            s = idleStim();
            s.reset    = ($urandom_range(0, 49) == 0);
            s.stall    = ($urandom_range(0, 3) == 0);
            s.flush    = ($urandom_range(0, 9) == 0);
            s.valid    = ($urandom_range(0, 3) != 0);
            s.op       = 4'($urandom);
            s.exc      = ($urandom_range(0, 15) == 0);
            s.cond     = 1'($urandom);
            s.isBranch = 1'($urandom);
            s.aluSrc   = 1'($urandom);
            s.pc       = $urandom;
            s.rs1      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            s.rs2      = ($urandom_range(0, 3) == 0) ? s.rs1 : $urandom;
            s.imm      = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
            s.rd       = 5'($urandom);
            s.rw       = 1'($urandom);
            s.mr       = 1'($urandom);
            s.mw       = 1'($urandom);
            applyStimulus(s);
        end

        applyStimulus(idleStim());
        repeat (3) @(posedge clk);
        #2;
        vectorCount++;
        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Single clock domain; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 in_valid  in  1  decode presents a valid instruction.
REQ-005 stall  in  1  downstream (memory stage) cannot accept; hold output register.
REQ-006 flush  in  1  kill instruction being captured this cycle.
REQ-007 alu_control  in  4  operation code, common package ALU encodings (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
REQ-008 alu_control_exception  in  1  illegal operation flag from ALU decode.
REQ-009 branch_condition  in  1  invert sense of branch test.
REQ-010 is_branch  in  1  instruction is conditional branch.
REQ-011 alu_src  in  1  0: operand B = rs2_data; 1: operand B = imm.
REQ-012 pc, rs1_data, rs2_data, imm  in  32 each  program counter, source operands, sign-extended immediate.
REQ-013 rd  in  5; reg_write, mem_read, mem_write  in  1 each  destination and control sidebands.
REQ-014 in_ready  out  1  equals !stall (combinational).
REQ-015 out_valid  out  1; alu_result  out  32; store_data  out  32; rd_out  out  5; reg_write_out, mem_read_out, mem_write_out  out  1 each; all registered.
REQ-016 branch_taken  out  1; branch_target  out  32; exception_out  out  1; all registered.

Function
REQ-017 Operand A = rs1_data; operand B = alu_src ? imm : rs2_data.
REQ-018 ADD/SUB: 32-bit modulo, carry/overflow discarded.
REQ-019 SLL/SRL/SRA: shift amount = operand B[4:0]; SRA replicates bit 31.
REQ-020 SLT: signed compare, result 1 or 0 zero-extended; SLTU: unsigned compare.
REQ-021 Undefined alu_control codes produce result 0 and assert exception.
REQ-022 taken = is_branch AND ((result != 0) XOR branch_condition).
REQ-023 branch_target = pc + imm, modulo 2^32.
REQ-024 Latency: one cycle; inputs sampled on rising clk edge when !stall, appear on outputs same edge.
REQ-025 stall=1 and flush=0: all output registers hold values; inputs ignored.
REQ-026 flush=1 (regardless of stall): next edge sets out_valid, branch_taken, exception_out, reg_write_out, mem_read_out, mem_write_out to 0; data outputs don't-care.
REQ-027 !stall, !flush, in_valid=0: capture bubble, same zeroing as REQ-026.
REQ-028 exception (alu_control_exception or REQ-021) with in_valid: exception_out=1, out_valid=1, reg_write_out=0, mem_write_out=0, mem_read_out=0, branch_taken=0.
REQ-029 branch_taken, reg_write_out, mem_* never asserted while out_valid=0.
REQ-030 store_data = rs2_data regardless of alu_src.

Reset
REQ-031 reset=1 at edge: out_valid, branch_taken, exception_out, reg_write_out, mem_read_out, mem_write_out = 0; alu_result, store_data, branch_target = 0; rd_out = 0.
REQ-032 reset has priority over flush and stall; in_ready still follows !stall during reset.
REQ-033 reset mid-stall discards held instruction; first valid output appears one edge after first accepted in_valid post-reset.

Verification
REQ-034 ADD, rs1=0x7FFFFFFF, rs2=1, alu_src=0 -> next edge alu_result=0x80000000, out_valid=1.
REQ-035 SLT rs1=0xFFFFFFFF, rs2=1 -> result 1; SLTU same operands -> result 0; SRA rs1=0x80000000, imm=4, alu_src=1 -> 0xF8000000.
REQ-036 Branch SUB, rs1=rs2=5, branch_condition=1, pc=0x100, imm=0x20 -> branch_taken=1, branch_target=0x120; branch_condition=0 -> branch_taken=0.
REQ-037 Capture instr A, raise stall 3 cycles while presenting B -> outputs hold A for 3 cycles, B appears first edge after stall drops.
REQ-038 stall=1 and flush=1 same cycle with valid output held -> next edge out_valid=0, reg_write_out=0.
REQ-039 alu_control_exception=1, reg_write=1, mem_write=1 -> exception_out=1, reg_write_out=0, mem_write_out=0; then reset -> all outputs 0.
